// File: rtl/debug_uart_sched_pkg.sv
// -----------------------------------------------------------------------------
// debug_uart_sched_pkg
// Shared definitions for the debug UART frame scheduler:
//   DEBUG_DATA_WIDTH : width of one UART byte
//   DEBUG_FRAME_SYNC : first byte of every frame on the wire
//   dbg_byte_t       : one UART byte
//   sched_state_e    : scheduler FSM states (ST_CSUM exists only when
//                      DEBUG_TX_CHECKSUM_EN is defined)
//   clamp_len        : limits a requested payload length to the frame maximum
// -----------------------------------------------------------------------------
package debug_uart_sched_pkg;

    localparam int DEBUG_DATA_WIDTH = 8;

    typedef logic [DEBUG_DATA_WIDTH-1:0] dbg_byte_t;

    localparam dbg_byte_t DEBUG_FRAME_SYNC = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LEN,
        ST_FETCH,
        ST_DATA
`ifdef DEBUG_TX_CHECKSUM_EN
        , ST_CSUM
`endif
    } sched_state_e;

    function automatic dbg_byte_t clamp_len(input dbg_byte_t raw, input dbg_byte_t max_len);
        return (raw > max_len) ? max_len : raw;
    endfunction

endpackage

// File: rtl/debug_rr_arbiter.sv
// -----------------------------------------------------------------------------
// debug_rr_arbiter
// Combinational round-robin pick: the first asserted request at or after the
// rotating pointer, searching upward and wrapping. Holds no state; the caller
// owns the pointer and registers the result.
// Ports:
//   req_i   [NUM_REQ-1:0] : request vector
//   ptr_i   [PTR_W-1:0]   : requester with highest priority this round
//   grant_o [NUM_REQ-1:0] : one-hot winner, zero when no request
//   idx_o   [PTR_W-1:0]   : binary index of the winner (0 when no request)
// -----------------------------------------------------------------------------
module debug_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   idx_o
);

    logic             found;
    int               pos;
    logic [PTR_W-1:0] pos_idx;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            // Wrap the search position without a modulo operator.
            pos = int'(ptr_i) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            pos_idx = PTR_W'(pos);
            if (!found && req_i[pos_idx]) begin
                found            = 1'b1;
                grant_o[pos_idx] = 1'b1;
                idx_o            = pos_idx;
            end
        end
    end

endmodule

// File: rtl/debug_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// debug_uart_tx_scheduler
// Shares the single OCD debug UART transmitter between NUM_REQ requesters.
// Frames are granted round-robin, one whole frame at a time, and sent as
//   0x5A, L, L payload bytes [, checksum]
// with one uart_tx_enable pulse per byte, each acknowledged by uart_tx_done.
// A per-byte watchdog aborts a frame that stalls for TX_TIMEOUT cycles.
// Build option: DEBUG_TX_CHECKSUM_EN appends an 8-bit sum of L and the payload.
// Ports:
//   clk, sync_reset        : clock, synchronous active-high reset
//   req        [N]         : frame request per requester (level)
//   req_len    [N*8]       : payload length per requester, sampled at grant
//   req_data   [N*8]       : payload byte per requester
//   req_valid  [N]         : payload byte valid
//   req_ready  [N]         : payload byte accepted (combinational, FETCH only)
//   grant      [N]         : one-hot owner of the frame in flight
//   uart_tx_enable         : one-cycle start pulse to the UART
//   uart_sbuf  [8]         : byte presented to the UART
//   uart_tx_done           : one-cycle byte-complete pulse from the UART
//   busy                   : scheduler not idle
//   frame_done / tx_error  : one-cycle pulses, frame completed / aborted
// -----------------------------------------------------------------------------
module debug_uart_tx_scheduler
    import debug_uart_sched_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int MAX_PAYLOAD = 64,
    parameter int TX_TIMEOUT  = 65535
) (
    input  logic                                clk,
    input  logic                                sync_reset,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*DEBUG_DATA_WIDTH-1:0] req_len,
    input  logic [NUM_REQ*DEBUG_DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  grant,
    output logic                                uart_tx_enable,
    output logic [DEBUG_DATA_WIDTH-1:0]         uart_sbuf,
    input  logic                                uart_tx_done,
    output logic                                busy,
    output logic                                frame_done,
    output logic                                tx_error
);

    localparam int        PTR_W   = $clog2(NUM_REQ);
    localparam int        WD_W    = $clog2(TX_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TX_TIMEOUT - 1);
    localparam dbg_byte_t MAX_LEN = dbg_byte_t'(MAX_PAYLOAD);

    // Where a frame goes after its last payload byte (or after LEN when L=0).
`ifdef DEBUG_TX_CHECKSUM_EN
    localparam sched_state_e ST_END = ST_CSUM;
`else
    localparam sched_state_e ST_END = ST_IDLE;
`endif

    sched_state_e         state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     gidx_q, gidx_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    dbg_byte_t            len_q, len_d;
    dbg_byte_t            cnt_q, cnt_d;
    dbg_byte_t            sbuf_q, sbuf_d;
    logic                 tx_en_q, tx_en_d;
    logic                 busy_q, busy_d;
    logic                 fdone_q, fdone_d;
    logic                 txerr_q, txerr_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;
`ifdef DEBUG_TX_CHECKSUM_EN
    dbg_byte_t            csum_q, csum_d;
`endif

    logic [NUM_REQ-1:0]   arb_grant;
    logic [PTR_W-1:0]     arb_idx;
    dbg_byte_t            arb_len_raw;
    dbg_byte_t            cur_data;
    logic                 wait_ph;
    logic                 done_ev;
    logic                 wd_exp;
    logic                 hs;
    logic                 more_data;
    logic [PTR_W-1:0]     ptr_inc;

    debug_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    // Per-requester byte selection: length of the arbiter winner, data of the owner.
    always_comb begin
        arb_len_raw = '0;
        cur_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == PTR_W'(i)) begin
                arb_len_raw = req_len[i*DEBUG_DATA_WIDTH +: DEBUG_DATA_WIDTH];
            end
            if (gidx_q == PTR_W'(i)) begin
                cur_data = req_data[i*DEBUG_DATA_WIDTH +: DEBUG_DATA_WIDTH];
            end
        end
    end

    // A wait phase is any byte state after its issue cycle; a done pulse
    // arriving anywhere else is not an acknowledgement and is dropped.
    assign wait_ph   = (state_q != ST_IDLE) && (state_q != ST_FETCH) && !tx_en_q;
    assign done_ev   = wait_ph && uart_tx_done;
    assign wd_exp    = (wait_ph || (state_q == ST_FETCH)) && (wdog_q == WD_LAST);
    assign hs        = (state_q == ST_FETCH) && |(req_valid & grant_q);
    assign more_data = (cnt_q + 8'd1) < len_q;
    assign ptr_inc   = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

    assign req_ready      = (state_q == ST_FETCH) ? grant_q : '0;
    assign grant          = grant_q;
    assign uart_tx_enable = tx_en_q;
    assign uart_sbuf      = sbuf_q;
    assign busy           = busy_q;
    assign frame_done     = fdone_q;
    assign tx_error       = txerr_q;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            sbuf_q  <= '0;
            tx_en_q <= 1'b0;
            busy_q  <= 1'b0;
            fdone_q <= 1'b0;
            txerr_q <= 1'b0;
            wdog_q  <= '0;
`ifdef DEBUG_TX_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sbuf_q  <= sbuf_d;
            tx_en_q <= tx_en_d;
            busy_q  <= busy_d;
            fdone_q <= fdone_d;
            txerr_q <= txerr_d;
            wdog_q  <= wdog_d;
`ifdef DEBUG_TX_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Next-state logic. An acknowledgement wins over a watchdog expiry in the
    // same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (done_ev)     state_d = ST_LEN;
                else if (wd_exp) state_d = ST_IDLE;
            end
            ST_LEN: begin
                if (done_ev)     state_d = (len_q != '0) ? ST_FETCH : ST_END;
                else if (wd_exp) state_d = ST_IDLE;
            end
            ST_FETCH: begin
                if (hs)          state_d = ST_DATA;
                else if (wd_exp) state_d = ST_IDLE;
            end
            ST_DATA: begin
                if (done_ev)     state_d = more_data ? ST_FETCH : ST_END;
                else if (wd_exp) state_d = ST_IDLE;
            end
`ifdef DEBUG_TX_CHECKSUM_EN
            ST_CSUM: begin
                if (done_ev || wd_exp) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values, driven by the transition being taken.
    always_comb begin
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sbuf_d  = sbuf_q;
        tx_en_d = 1'b0;
        fdone_d = 1'b0;
        txerr_d = 1'b0;
        busy_d  = (state_d != ST_IDLE);
        // Every state change is either an issue or a FETCH entry, so the
        // watchdog restarts on any transition.
        wdog_d  = ((state_d != state_q) || (state_q == ST_IDLE)) ? '0 : wdog_q + 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (state_q == ST_IDLE) begin
            if (state_d == ST_SYNC) begin
                grant_d = arb_grant;
                gidx_d  = arb_idx;
                len_d   = clamp_len(arb_len_raw, MAX_LEN);
                cnt_d   = '0;
                sbuf_d  = DEBUG_FRAME_SYNC;
                tx_en_d = 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
                csum_d  = clamp_len(arb_len_raw, MAX_LEN);
`endif
            end
        end else if (state_d == ST_IDLE) begin
            // Leaving a frame: an acknowledged last byte is a finish,
            // anything else is a watchdog abort. Both rotate the pointer.
            grant_d = '0;
            ptr_d   = ptr_inc;
            fdone_d = done_ev;
            txerr_d = !done_ev;
        end else if (state_d != state_q) begin
            case (state_d)
                ST_LEN: begin
                    sbuf_d  = len_q;
                    tx_en_d = 1'b1;
                end
                ST_DATA: begin
                    sbuf_d  = cur_data;
                    tx_en_d = 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
                    csum_d  = csum_q + cur_data;
`endif
                end
`ifdef DEBUG_TX_CHECKSUM_EN
                ST_CSUM: begin
                    sbuf_d  = csum_q;
                    tx_en_d = 1'b1;
                end
`endif
                default: ;
            endcase
            if (state_q == ST_DATA) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_debug_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_debug_uart_tx_scheduler
// Scoreboard bench: each frame's expected owner and wire bytes are queued when
// the stimulus is set up; a UART model and a grant monitor pop and compare as
// the scheduler produces them.
// -----------------------------------------------------------------------------
module tb_debug_uart_tx_scheduler;

    localparam int NUM_REQ     = 2;
    localparam int MAX_PAYLOAD = 64;
    localparam int TX_TIMEOUT  = 40;
    localparam int DONE_LAT    = 10;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic [1:0]  req;
    logic [15:0] req_len;
    logic [15:0] req_data;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic        uart_tx_enable;
    logic [7:0]  uart_sbuf;
    logic        uart_tx_done;
    logic        busy;
    logic        frame_done;
    logic        tx_error;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int en_cyc = 0;
    int done_budget = -1;
    int hs_cnt0 = 0;
    int hs_cnt1 = 0;
    logic ready_seen = 1'b0;
    logic [1:0] hs_pend = 2'b00;

    logic [7:0] exp_q[$];
    int         own_q[$];
    logic [7:0] pq0[$];
    logic [7:0] pq1[$];

    debug_uart_tx_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .MAX_PAYLOAD (MAX_PAYLOAD),
        .TX_TIMEOUT  (TX_TIMEOUT)
    ) dut (
        .clk            (clk),
        .sync_reset     (sync_reset),
        .req            (req),
        .req_len        (req_len),
        .req_data       (req_data),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .grant          (grant),
        .uart_tx_enable (uart_tx_enable),
        .uart_sbuf      (uart_sbuf),
        .uart_tx_done   (uart_tx_done),
        .busy           (busy),
        .frame_done     (frame_done),
        .tx_error       (tx_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Queue one frame: owner, wire bytes and the requester's payload.
    task automatic push_frame(input int r, input int lraw, input logic [7:0] base, input logic [7:0] step);
        int         l;
        logic [7:0] b;
        logic [7:0] sum;
        l = (lraw > MAX_PAYLOAD) ? MAX_PAYLOAD : lraw;
        own_q.push_back(r);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'(l));
        sum = 8'(l);
        for (int k = 0; k < lraw; k++) begin
            b = base + 8'(k) * step;
            if (r == 0) pq0.push_back(b);
            else        pq1.push_back(b);
            if (k < l) begin
                exp_q.push_back(b);
                sum = sum + b;
            end
        end
`ifdef DEBUG_TX_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
        req_len[8*r +: 8] = 8'(lraw);
    endtask

    task automatic run_frames(input int nf, input int budget, output int fd, output int te);
        fd = 0;
        te = 0;
        for (int n = 0; n < budget && (fd + te) < nf; n++) begin
            @(negedge clk);
            if (frame_done) fd++;
            if (tx_error)   te++;
        end
    endtask

    task automatic flush_all();
        exp_q.delete();
        own_q.delete();
        pq0.delete();
        pq1.delete();
    endtask

    task automatic do_reset();
        sync_reset = 1'b1;
        req        = 2'b00;
        repeat (2) @(negedge clk);
        flush_all();
        sync_reset = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_grant"},      grant, 0);
        check_eq({pfx, "_tx_enable"},  uart_tx_enable, 0);
        check_eq({pfx, "_sbuf"},       uart_sbuf, 0);
        check_eq({pfx, "_req_ready"},  req_ready, 0);
        check_eq({pfx, "_busy"},       busy, 0);
        check_eq({pfx, "_frame_done"}, frame_done, 0);
        check_eq({pfx, "_tx_error"},   tx_error, 0);
    endtask

    // UART model: checks each issued byte against the scoreboard, holds the
    // byte under watch, and acknowledges DONE_LAT cycles after the enable.
    initial begin : uart_model
        int         cd;
        logic [7:0] last_byte;
        uart_tx_done = 1'b0;
        cd = 0;
        last_byte = 8'h00;
        forever begin
            @(negedge clk);
            uart_tx_done = 1'b0;
            if (sync_reset) begin
                cd = 0;
            end else if (uart_tx_enable) begin
                en_cyc    = cyc;
                last_byte = uart_sbuf;
                if (exp_q.size() == 0) check_eq("byte_expected", exp_q.size(), 1);
                else                   check_eq("uart_sbuf", uart_sbuf, exp_q.pop_front());
                cd = DONE_LAT;
            end else if (cd > 0) begin
                check_eq("sbuf_stable", uart_sbuf, last_byte);
                cd--;
                if (cd == 0 && done_budget != 0) begin
                    uart_tx_done = 1'b1;
                    if (done_budget > 0) done_budget--;
                end
            end
        end
    end

    // Requester model: presents queued payload with random valid gaps and
    // retires a byte after each handshake.
    initial begin : feeder
        req_valid = 2'b00;
        req_data  = 16'h0000;
        forever begin
            @(negedge clk);
            if (hs_pend[0] && pq0.size() > 0) begin void'(pq0.pop_front()); hs_cnt0++; end
            if (hs_pend[1] && pq1.size() > 0) begin void'(pq1.pop_front()); hs_cnt1++; end
            req_valid[0]   = (pq0.size() > 0) && ($urandom_range(0, 3) != 0);
            req_data[7:0]  = (pq0.size() > 0) ? pq0[0] : 8'h00;
            req_valid[1]   = (pq1.size() > 0) && ($urandom_range(0, 3) != 0);
            req_data[15:8] = (pq1.size() > 0) ? pq1[0] : 8'h00;
            if (|req_ready) ready_seen = 1'b1;
            hs_pend = req_valid & req_ready;
        end
    end

    // Grant monitor: every new frame must go to the expected owner and
    // start its SYNC byte in the same cycle.
    initial begin : grant_mon
        logic [1:0] prev;
        int         o;
        prev = 2'b00;
        forever begin
            @(negedge clk);
            if (grant != 2'b00 && prev == 2'b00) begin
                if (own_q.size() == 0) begin
                    check_eq("grant_expected", own_q.size(), 1);
                end else begin
                    o = own_q.pop_front();
                    check_eq("grant_owner",  grant, 1 << o);
                    check_eq("grant_enable", uart_tx_enable, 1);
                    check_eq("grant_busy",   busy, 1);
                end
            end
            prev = grant;
        end
    end

    initial begin : global_guard
        #400000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin : main
        int fd;
        int te;
        int err_at;
        int n;
        sync_reset = 1'b1;
        req        = 2'b00;
        req_len    = 16'h0000;
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        sync_reset = 1'b0;

        // Basic two-byte frame from requester 0.
        push_frame(0, 2, 8'h11, 8'h11);
        req = 2'b01;
        @(negedge clk);
        check_eq("t1_grant_latency", grant, 2'b01);
        check_eq("t1_sbuf_sync", uart_sbuf, 8'h5A);
        run_frames(1, 2000, fd, te);
        req = 2'b00;
        check_eq("t1_frame_done", fd, 1);
        check_eq("t1_tx_error", te, 0);
        check_eq("t1_bytes_left", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check_eq("t1_idle_busy", busy, 0);

        // Simultaneous requests from reset, then held for strict alternation.
        do_reset();
        push_frame(0, 1, 8'hA0, 8'h01);
        push_frame(1, 3, 8'hB0, 8'h01);
        push_frame(0, 1, 8'hC0, 8'h01);
        push_frame(1, 3, 8'hD0, 8'h01);
        req = 2'b11;
        run_frames(2, 3000, fd, te);
        check_eq("t2_first_pair", fd, 2);
        run_frames(2, 3000, fd, te);
        req = 2'b00;
        check_eq("t2_second_pair", fd, 2);
        check_eq("t2_owners_left", own_q.size(), 0);
        check_eq("t2_bytes_left", exp_q.size(), 0);

        // Zero-length frame: no payload fetch at all.
        ready_seen = 1'b0;
        push_frame(0, 0, 8'h00, 8'h00);
        req = 2'b01;
        run_frames(1, 2000, fd, te);
        req = 2'b00;
        check_eq("t3_frame_done", fd, 1);
        check_eq("t3_ready_seen", ready_seen, 0);
        check_eq("t3_bytes_left", exp_q.size(), 0);

        // Oversized length clamps to MAX_PAYLOAD.
        hs_cnt1 = 0;
        push_frame(1, 200, 8'h00, 8'h01);
        req = 2'b10;
        run_frames(1, 6000, fd, te);
        req = 2'b00;
        check_eq("t4_frame_done", fd, 1);
        check_eq("t4_handshakes", hs_cnt1, 64);
        check_eq("t4_bytes_left", exp_q.size(), 0);
        pq1.delete();

        // Withhold the LEN acknowledgement: watchdog abort.
        own_q.push_back(0);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h01);
        pq0.push_back(8'h77);
        req_len[7:0] = 8'd1;
        done_budget  = 1;
        req = 2'b01;
        run_frames(1, 500, fd, te);
        err_at = cyc;
        req = 2'b00;
        check_eq("t5_tx_error", te, 1);
        check_eq("t5_frame_done", fd, 0);
        check_eq("t5_timeout_cycles", err_at - en_cyc, TX_TIMEOUT);
        check_eq("t5_grant_cleared", grant, 0);
        check_eq("t5_bytes_left", exp_q.size(), 0);
        done_budget = -1;
        pq0.delete();

        // Pointer moved past requester 0: requester 1 wins a tie next.
        push_frame(1, 0, 8'h00, 8'h00);
        push_frame(0, 0, 8'h00, 8'h00);
        req = 2'b11;
        run_frames(2, 2000, fd, te);
        req = 2'b00;
        check_eq("t5_ptr_frames", fd, 2);
        check_eq("t5_ptr_owners_left", own_q.size(), 0);

        // Reset in the middle of a payload byte.
        hs_cnt1 = 0;
        push_frame(1, 4, 8'h30, 8'h01);
        req = 2'b10;
        n = 0;
        while (hs_cnt1 < 1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_reached_data", hs_cnt1, 1);
        repeat (3) @(negedge clk);
        sync_reset = 1'b1;
        req = 2'b00;
        @(negedge clk);
        check_all_zero("t6_rst");
        flush_all();
        sync_reset = 1'b0;
        @(negedge clk);
        check_eq("t6_idle_after_rst", busy, 0);
        push_frame(0, 1, 8'h5C, 8'h00);
        req = 2'b01;
        @(negedge clk);
        check_eq("t6_restart_grant", grant, 2'b01);
        check_eq("t6_restart_sync", uart_sbuf, 8'h5A);
        run_frames(1, 2000, fd, te);
        req = 2'b00;
        check_eq("t6_frame_done", fd, 1);
        check_eq("t6_bytes_left", exp_q.size(), 0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
